// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares the single-port unified instruction/data memory between the core's
//   control path (CPU) and a DMA/debug requester. One access at a time is
//   sequenced IDLE -> ISSUE -> (WAIT for reads) -> DONE, and the requester gets
//   a one-cycle ack. The CPU wins ties unless it has already won MAX_STALL
//   consecutive ties against a waiting DMA request.
//
// Ports
//   clk, rst                       clock, synchronous active-high reset
//   cpu_req_i/we_i/addr_i/wdata_i  CPU request, held until cpu_ack_o
//   cpu_ack_o, cpu_rdata_o         CPU completion pulse, read data (held)
//   cpu_stall_o                    freezes the CPU control FSM while pending
//   dma_req_i/we_i/addr_i/wdata_i  DMA request, held until dma_ack_o
//   dma_ack_o, dma_rdata_o         DMA completion pulse, read data (held)
//   mem_en_o/we_o/addr_o/wdata_o   memory strobe, one cycle per transaction
//   mem_rdata_i                    memory read data, valid MEM_LAT cycles after mem_en_o
module mem_port_arbiter #(
    parameter int AW        = 8,
    parameter int DW        = 32,
    parameter int MEM_LAT   = 2,
    parameter int MAX_STALL = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cpu_req_i,
    input  logic          cpu_we_i,
    input  logic [AW-1:0] cpu_addr_i,
    input  logic [DW-1:0] cpu_wdata_i,
    output logic          cpu_ack_o,
    output logic [DW-1:0] cpu_rdata_o,
    output logic          cpu_stall_o,
    input  logic          dma_req_i,
    input  logic          dma_we_i,
    input  logic [AW-1:0] dma_addr_i,
    input  logic [DW-1:0] dma_wdata_i,
    output logic          dma_ack_o,
    output logic [DW-1:0] dma_rdata_o,
    output logic          mem_en_o,
    output logic          mem_we_o,
    output logic [AW-1:0] mem_addr_o,
    output logic [DW-1:0] mem_wdata_o,
    input  logic [DW-1:0] mem_rdata_i
);

    localparam int CW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam int SW = (MAX_STALL > 0) ? $clog2(MAX_STALL + 1) : 1;
    localparam logic [CW-1:0] LAT_LAST  = CW'(MEM_LAT - 1);
    localparam logic [SW-1:0] STALL_MAX = SW'(MAX_STALL);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]    state_q, state_d;
    logic          owner_q, owner_d;      // 1 = DMA owns the current access
    logic          we_q, we_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic [CW-1:0] wcnt_q, wcnt_d;
    logic [SW-1:0] starve_q, starve_d;
    logic [DW-1:0] cpu_rdata_q, cpu_rdata_d;
    logic [DW-1:0] dma_rdata_q, dma_rdata_d;

    logic any_req, dma_win;
    assign any_req = cpu_req_i | dma_req_i;
    // With MAX_STALL=0 the counter is stuck at 0 == STALL_MAX, so DMA wins every tie.
    assign dma_win = dma_req_i & (~cpu_req_i | (starve_q == STALL_MAX));

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        wcnt_d      = wcnt_q;
        starve_d    = starve_q;
        cpu_rdata_d = cpu_rdata_q;
        dma_rdata_d = dma_rdata_q;
        case (state_q)
            S_IDLE: begin
                if (any_req) begin
                    state_d = S_ISSUE;
                    owner_d = dma_win;
                    we_d    = dma_win ? dma_we_i    : cpu_we_i;
                    addr_d  = dma_win ? dma_addr_i  : cpu_addr_i;
                    wdata_d = dma_win ? dma_wdata_i : cpu_wdata_i;
                end
                // Only a CPU win over a waiting DMA request counts toward starvation.
                if (!dma_req_i || dma_win)
                    starve_d = '0;
                else if (starve_q != STALL_MAX)
                    starve_d = starve_q + 1'b1;
            end
            S_ISSUE: begin
                state_d = we_q ? S_DONE : S_WAIT;
                wcnt_d  = '0;
            end
            S_WAIT: begin
                if (wcnt_q == LAT_LAST) begin
                    state_d = S_DONE;
                    if (owner_q) dma_rdata_d = mem_rdata_i;
                    else         cpu_rdata_d = mem_rdata_i;
                end else begin
                    wcnt_d = wcnt_q + 1'b1;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            owner_q     <= 1'b0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            wcnt_q      <= '0;
            starve_q    <= '0;
            cpu_rdata_q <= '0;
            dma_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            wcnt_q      <= wcnt_d;
            starve_q    <= starve_d;
            cpu_rdata_q <= cpu_rdata_d;
            dma_rdata_q <= dma_rdata_d;
        end
    end

    assign mem_en_o    = (state_q == S_ISSUE);
    assign mem_we_o    = mem_en_o & we_q;
    assign mem_addr_o  = mem_en_o ? addr_q  : '0;
    assign mem_wdata_o = mem_en_o ? wdata_q : '0;

    assign cpu_ack_o   = (state_q == S_DONE) & ~owner_q;
    assign dma_ack_o   = (state_q == S_DONE) &  owner_q;
    assign cpu_rdata_o = cpu_rdata_q;
    assign dma_rdata_o = dma_rdata_q;
    assign cpu_stall_o = cpu_req_i & ~cpu_ack_o;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
//   Directed scenarios followed by randomized CPU/DMA traffic. A transaction
//   level model predicts grant, mem strobe cycle, ack cycle and read data from
//   the arbitration and latency rules; an environment memory answers reads
//   with garbage outside the valid cycle.
module tb_mem_port_arbiter;
    localparam int AW = 8, DW = 32, MEM_LAT = 2, MAX_STALL = 4;

    logic clk = 1'b0;
    logic rst;
    logic cpu_req, cpu_we, dma_req, dma_we;
    logic [AW-1:0] cpu_addr, dma_addr;
    logic [DW-1:0] cpu_wdata, dma_wdata;
    logic cpu_ack, cpu_stall, dma_ack, mem_en, mem_we;
    logic [DW-1:0] cpu_rdata, dma_rdata, mem_wdata, mem_rdata;
    logic [AW-1:0] mem_addr;

    always #5 clk = ~clk;

    mem_port_arbiter #(.AW(AW), .DW(DW), .MEM_LAT(MEM_LAT), .MAX_STALL(MAX_STALL)) dut (
        .clk(clk), .rst(rst),
        .cpu_req_i(cpu_req), .cpu_we_i(cpu_we), .cpu_addr_i(cpu_addr), .cpu_wdata_i(cpu_wdata),
        .cpu_ack_o(cpu_ack), .cpu_rdata_o(cpu_rdata), .cpu_stall_o(cpu_stall),
        .dma_req_i(dma_req), .dma_we_i(dma_we), .dma_addr_i(dma_addr), .dma_wdata_i(dma_wdata),
        .dma_ack_o(dma_ack), .dma_rdata_o(dma_rdata),
        .mem_en_o(mem_en), .mem_we_o(mem_we), .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata),
        .mem_rdata_i(mem_rdata)
    );

    function automatic logic [DW-1:0] init_val(input int a);
        return (DW'(a) * 32'h9E37_79B1) ^ 32'h5A5A_0000;
    endfunction

    // environment memory: data valid only in the cycle MEM_LAT after mem_en
    int pcyc = 0;
    int rd_due = -1;
    logic [DW-1:0] rd_data = '0, garbage = '0;
    logic [DW-1:0] env_mem [256];
    bit env_wr [256];
    always @(posedge clk) begin
        pcyc <= pcyc + 1;
        garbage <= $urandom;
        if (mem_en === 1'b1) begin
            if (mem_we) begin
                env_mem[mem_addr] <= mem_wdata;
                env_wr[mem_addr]  <= 1'b1;
            end else begin
                rd_due  <= pcyc + MEM_LAT;
                rd_data <= env_wr[mem_addr] ? env_mem[mem_addr] : init_val(int'(mem_addr));
            end
        end
    end
    assign mem_rdata = (pcyc == rd_due) ? rd_data : garbage;

    // transaction-level reference model
    int n_vec = 0, n_err = 0;
    int cyc_n, t_issue, t_ack, streak;
    bit busy, done_now, m_dma, m_rd;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata, m_rval, exp_crd, exp_drd;
    logic [DW-1:0] ref_mem [256];

    task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_vec++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic check_cycle();
        bit e_ack, e_en;
        e_ack = busy && (cyc_n == t_ack);
        e_en  = busy && (cyc_n == t_issue);
        if (e_ack && m_rd) begin
            if (m_dma) exp_drd = m_rval;
            else       exp_crd = m_rval;
        end
        chk("cpu_ack",   DW'(cpu_ack),   DW'(e_ack && !m_dma));
        chk("dma_ack",   DW'(dma_ack),   DW'(e_ack && m_dma));
        chk("mem_en",    DW'(mem_en),    DW'(e_en));
        chk("mem_we",    DW'(mem_we),    DW'(e_en && !m_rd));
        chk("mem_addr",  DW'(mem_addr),  e_en ? DW'(m_addr) : '0);
        chk("mem_wdata", mem_wdata,      e_en ? m_wdata : '0);
        chk("cpu_stall", DW'(cpu_stall), DW'(cpu_req && !(e_ack && !m_dma)));
        chk("cpu_rdata", cpu_rdata, exp_crd);
        chk("dma_rdata", dma_rdata, exp_drd);
        done_now = e_ack;
        if (e_ack) busy = 0;
    endtask

    // decide what the coming edge does with the inputs now applied
    task automatic commit();
        bit idle, dw;
        idle = !busy && !done_now;
        dw = 0;
        if (rst) begin
            busy = 0; streak = 0; exp_crd = '0; exp_drd = '0;
        end else if (idle) begin
            if (cpu_req || dma_req) begin
                dw      = dma_req && (!cpu_req || streak >= MAX_STALL);
                m_dma   = dw;
                m_rd    = dw ? !dma_we : !cpu_we;
                m_addr  = dw ? dma_addr : cpu_addr;
                m_wdata = dw ? dma_wdata : cpu_wdata;
                busy    = 1;
                t_issue = cyc_n + 1;
                t_ack   = cyc_n + (m_rd ? MEM_LAT + 2 : 2);
                if (m_rd) m_rval = ref_mem[m_addr];
                else      ref_mem[m_addr] = m_wdata;
            end
            if (!dma_req || dw) streak = 0;
            else                streak++;
        end
    endtask

    task automatic step();
        commit();
        @(negedge clk);
        cyc_n++;
        check_cycle();
    endtask

    task automatic wait_ack(input bit dma, output int lat);
        int t0;
        bit seen;
        t0 = cyc_n; seen = 0; lat = -1;
        for (int i = 0; i < 40 && !seen; i++) begin
            step();
            if (dma ? dma_ack : cpu_ack) begin
                seen = 1;
                lat = cyc_n - t0;
            end
        end
        chk(dma ? "dma_ack_seen" : "cpu_ack_seen", DW'(seen), DW'(1));
    endtask

    task automatic set_cpu(input bit r, input bit w, input logic [AW-1:0] a, input logic [DW-1:0] d);
        cpu_req = r; cpu_we = w; cpu_addr = a; cpu_wdata = d;
    endtask

    task automatic set_dma(input bit r, input bit w, input logic [AW-1:0] a, input logic [DW-1:0] d);
        dma_req = r; dma_we = w; dma_addr = a; dma_wdata = d;
    endtask

    initial begin
        int lat, k;
        int order [10];
        rst = 1;
        set_cpu(0, 0, '0, '0);
        set_dma(0, 0, '0, '0);
        cyc_n = 0; busy = 0; done_now = 0; streak = 0;
        exp_crd = '0; exp_drd = '0; m_dma = 0; m_rd = 0;
        m_addr = '0; m_wdata = '0; m_rval = '0; t_issue = -1; t_ack = -1;
        for (int a = 0; a < 256; a++) ref_mem[a] = init_val(a);
        repeat (3) @(negedge clk);
        check_cycle();                              // reset state

        // both requests in the first cycle after reset: CPU first
        rst = 0;
        set_cpu(1, 0, 8'h05, $urandom);
        set_dma(1, 0, 8'h06, $urandom);
        wait_ack(0, lat);
        chk("t4_cpu_lat", DW'(lat), DW'(MEM_LAT + 2));
        set_cpu(0, 0, '0, '0);
        wait_ack(1, lat);
        chk("t4_dma_lat", DW'(lat), DW'(MEM_LAT + 3));
        set_dma(0, 0, '0, '0);
        step();

        // DMA write alone
        set_dma(1, 1, 8'h3F, 32'h1234_5678);
        wait_ack(1, lat);
        chk("t2_lat", DW'(lat), DW'(2));
        set_dma(0, 0, '0, '0);
        step();
        chk("t2_mem", env_mem[8'h3F], 32'h1234_5678);

        // CPU read of a location DMA just wrote
        set_dma(1, 1, 8'h10, 32'hDEAD_BEEF);
        wait_ack(1, lat);
        set_dma(0, 0, '0, '0);
        step();
        set_cpu(1, 0, 8'h10, $urandom);
        wait_ack(0, lat);
        chk("t1_lat", DW'(lat), DW'(MEM_LAT + 2));
        chk("t1_rdata", cpu_rdata, 32'hDEAD_BEEF);
        set_cpu(0, 0, '0, '0);
        step();

        // back-to-back CPU reads, then a DMA read must not disturb cpu_rdata
        set_cpu(1, 0, 8'h01, $urandom);
        wait_ack(0, lat);
        set_cpu(1, 0, 8'h02, $urandom);
        wait_ack(0, lat);
        chk("t6_gap", DW'(lat), DW'(MEM_LAT + 3));
        set_cpu(0, 0, '0, '0);
        set_dma(1, 0, 8'h10, $urandom);
        wait_ack(1, lat);
        chk("t6_dma_rdata", dma_rdata, 32'hDEAD_BEEF);
        chk("t6_cpu_hold", cpu_rdata, init_val(2));
        set_dma(0, 0, '0, '0);
        step();

        // both requesters saturated: CPU x MAX_STALL then DMA, repeating
        for (int j = 0; j < 10; j++) order[j] = 7;
        k = 0;
        set_cpu(1, $urandom_range(1), AW'($urandom_range(15)), $urandom);
        set_dma(1, $urandom_range(1), AW'($urandom_range(15)), $urandom);
        for (int i = 0; i < 300 && k < 10; i++) begin
            step();
            if (cpu_ack) begin
                order[k] = 0; k++;
                set_cpu(1, $urandom_range(1), AW'($urandom_range(15)), $urandom);
            end else if (dma_ack) begin
                order[k] = 1; k++;
                set_dma(1, $urandom_range(1), AW'($urandom_range(15)), $urandom);
            end
        end
        chk("t3_count", DW'(k), DW'(10));
        for (int j = 0; j < 10; j++)
            chk($sformatf("t3_order%0d", j), DW'(order[j]), DW'((j % (MAX_STALL + 1) == MAX_STALL) ? 1 : 0));
        set_cpu(0, 0, '0, '0);
        set_dma(0, 0, '0, '0);
        step();

        // reset during the WAIT of a CPU read
        set_cpu(1, 0, 8'h33, $urandom);
        step();                                     // ISSUE
        step();                                     // WAIT
        rst = 1;
        set_cpu(0, 0, '0, '0);
        step();
        chk("t5_mem_en", DW'(mem_en), '0);
        chk("t5_ack", DW'(cpu_ack), '0);
        chk("t5_rdata_clr", cpu_rdata, '0);
        rst = 0;
        set_cpu(1, 0, 8'h0A, $urandom);
        wait_ack(0, lat);
        chk("t5_lat", DW'(lat), DW'(MEM_LAT + 2));
        chk("t5_rdata", cpu_rdata, ref_mem[8'h0A]);
        set_cpu(0, 0, '0, '0);
        step();

        // randomized traffic with occasional resets and post-grant input noise
        for (int i = 0; i < 800; i++) begin
            if (rst) rst = 0;
            else if ($urandom_range(99) == 0) rst = 1;
            if (cpu_req && cpu_ack)
                set_cpu($urandom_range(1), $urandom_range(1), AW'($urandom_range(15)), $urandom);
            else if (!cpu_req) begin
                if ($urandom_range(2) == 0)
                    set_cpu(1, $urandom_range(1), AW'($urandom_range(15)), $urandom);
            end else if ($urandom_range(3) == 0)
                set_cpu(1, $urandom_range(1), AW'($urandom_range(15)), $urandom);
            if (dma_req && dma_ack)
                set_dma($urandom_range(1), $urandom_range(1), AW'($urandom_range(15)), $urandom);
            else if (!dma_req) begin
                if ($urandom_range(2) == 0)
                    set_dma(1, $urandom_range(1), AW'($urandom_range(15)), $urandom);
            end else if ($urandom_range(3) == 0)
                set_dma(1, $urandom_range(1), AW'($urandom_range(15)), $urandom);
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
